psum_writeback: RTL and testbench

//  Drains partial-sum vectors from the corelet output FIFO and writes them into psum SRAM.

---
 rtl/core_pkg.sv | 31 +++
 rtl/psum_writeback_if.sv | 42 ++++
 rtl/psum_addr_gen.sv | 56 +++++
 rtl/psum_writeback.sv | 113 +++++++++++
 tb/tb_psum_writeback.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
//------------------------------------------------------------------------------
// Module : core_pkg
// Shared widths, vector type and writeback FSM states for the psum datapath.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package core_pkg;
    localparam int COL          = 8;
    localparam int PSUM_BW      = 16;
    localparam int DEF_NIJ_LEN  = 36;
    localparam int DEF_KIJ_LEN  = 9;
    localparam int ADDR_W       = 11;
    localparam int PSUM_VEC_W   = COL * PSUM_BW;

    typedef logic [COL-1:0][PSUM_BW-1:0] psum_vec_t;
    typedef logic [ADDR_W-1:0]           addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter width that stays legal for a length of 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

`default_nettype wire

// File: rtl/psum_writeback_if.sv
//------------------------------------------------------------------------------
// Module : psum_writeback_if
// Control, ofifo and psum SRAM write bus; mem_ready exists with PSUM_WB_STALL_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface psum_writeback_if import core_pkg::*;;
    logic                  start;
    addr_t                 base_addr;
    psum_vec_t             ofifo_out;
    logic                  ofifo_valid;
    logic                  ofifo_rd;
    logic                  mem_wr;
    addr_t                 mem_addr;
    logic [PSUM_VEC_W-1:0] mem_din;
    logic                  busy;
    logic                  done;
`ifdef PSUM_WB_STALL_EN
    logic                  mem_ready;

    modport master (
        output start, base_addr, ofifo_out, ofifo_valid, mem_ready,
        input  ofifo_rd, mem_wr, mem_addr, mem_din, busy, done
    );
    modport slave (
        input  start, base_addr, ofifo_out, ofifo_valid, mem_ready,
        output ofifo_rd, mem_wr, mem_addr, mem_din, busy, done
    );
`else
    modport master (
        output start, base_addr, ofifo_out, ofifo_valid,
        input  ofifo_rd, mem_wr, mem_addr, mem_din, busy, done
    );
    modport slave (
        input  start, base_addr, ofifo_out, ofifo_valid,
        output ofifo_rd, mem_wr, mem_addr, mem_din, busy, done
    );
`endif
endinterface

`default_nettype wire

// File: rtl/psum_addr_gen.sv
//------------------------------------------------------------------------------
// Module : psum_addr_gen
// nij/kij counters with wrap, last-pop flag and base + kij*NIJ_LEN + nij address.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module psum_addr_gen import core_pkg::*; #(
    parameter int NIJ_LEN = DEF_NIJ_LEN,
    parameter int KIJ_LEN = DEF_KIJ_LEN
) (
    input  wire logic  clk,
    input  wire logic  reset,
    input  wire logic  clear,
    input  wire logic  advance,
    input  wire addr_t base_in,
    output addr_t      addr,
    output logic       last
);
    localparam int NIJ_W = cnt_w(NIJ_LEN);
    localparam int KIJ_W = cnt_w(KIJ_LEN);
    localparam logic [NIJ_W-1:0] NIJ_MAX = NIJ_W'(NIJ_LEN - 1);
    localparam logic [KIJ_W-1:0] KIJ_MAX = KIJ_W'(KIJ_LEN - 1);

    logic [NIJ_W-1:0] nij;
    logic [KIJ_W-1:0] kij;
    addr_t            base;
    logic             nij_wrap;

    assign nij_wrap = (nij == NIJ_MAX);
    assign last     = nij_wrap && (kij == KIJ_MAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            nij  <= '0;
            kij  <= '0;
            base <= '0;
        end else if (clear) begin
            nij  <= '0;
            kij  <= '0;
            base <= base_in;
        end else if (advance) begin
            if (nij_wrap) begin
                nij <= '0;
                kij <= last ? '0 : kij + 1'b1;
            end else begin
                nij <= nij + 1'b1;
            end
        end
    end

    // Modulo 2^ADDR_W; overflow past the top of the SRAM wraps silently.
    assign addr = base + ADDR_W'(kij) * ADDR_W'(NIJ_LEN) + ADDR_W'(nij);
endmodule

`default_nettype wire

// File: rtl/psum_writeback.sv
//------------------------------------------------------------------------------
// Module : psum_writeback
// Drains ofifo psum vectors into psum SRAM for one layer pass.
// Option : PSUM_WB_STALL_EN adds mem_ready backpressure on the SRAM write.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module psum_writeback import core_pkg::*; #(
    parameter int NIJ_LEN = DEF_NIJ_LEN,
    parameter int KIJ_LEN = DEF_KIJ_LEN
) (
    input  wire logic        clk,
    input  wire logic        reset,
    psum_writeback_if.slave  bus
);
    state_t state;
    state_t state_nxt;
    logic   stall;
    logic   pop;
    logic   done_c;
    logic   accept_start;
    logic   last;
    addr_t  wr_addr;

    logic                  mem_wr;
    addr_t                 mem_addr;
    logic [PSUM_VEC_W-1:0] mem_din;

`ifdef PSUM_WB_STALL_EN
    assign stall = mem_wr & ~bus.mem_ready;
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        done_c       = 1'b0;
        accept_start = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept_start = 1'b1;
                    state_nxt    = DRAIN;
                end
            end
            DRAIN: begin
                pop = bus.ofifo_valid & ~stall;
                if (pop && last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Final write is on the bus; leave only once the SRAM takes it.
                if (!stall) begin
                    done_c    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Reset cycle must neither pop the FIFO nor report completion.
        if (!reset) begin
            pop    = 1'b0;
            done_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else if (pop) begin
            mem_wr   <= 1'b1;
            mem_addr <= wr_addr;
            mem_din  <= bus.ofifo_out;
        end else if (!stall) begin
            mem_wr   <= 1'b0;
        end
    end

    psum_addr_gen #(
        .NIJ_LEN (NIJ_LEN),
        .KIJ_LEN (KIJ_LEN)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept_start),
        .advance (pop),
        .base_in (bus.base_addr),
        .addr    (wr_addr),
        .last    (last)
    );

    assign bus.ofifo_rd = pop;
    assign bus.done     = done_c;
    assign bus.busy     = (state != IDLE);
    assign bus.mem_wr   = mem_wr;
    assign bus.mem_addr = mem_addr;
    assign bus.mem_din  = mem_din;
endmodule

`default_nettype wire

// File: tb/tb_psum_writeback.sv
//------------------------------------------------------------------------------
// Module : tb_psum_writeback
// Random-data bench for psum_writeback against a pass-level reference model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_psum_writeback;
    import core_pkg::*;

    localparam int NIJ   = 4;
    localparam int KIJ   = 2;
    localparam int TOTAL = NIJ * KIJ;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    psum_writeback_if bus();

    psum_writeback #(
        .NIJ_LEN (NIJ),
        .KIJ_LEN (KIJ)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a pass is TOTAL pops written to base, base+1, ... in order.
    bit        m_busy;
    bit        m_in_done;
    bit        m_wr;
    int        m_idx;
    addr_t     m_base;
    addr_t     m_addr;
    psum_vec_t m_din;
    psum_vec_t head;
    bit        mr;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic psum_vec_t rnd_vec();
        psum_vec_t v;
        for (int i = 0; i < COL; i++) v[i] = PSUM_BW'($urandom);
        return v;
    endfunction

    // Entered just after a falling edge; leaves just after the next falling edge.
    task automatic do_cycle(input bit rst_n, input bit st, input addr_t b, input bit vld);
        bit stall;
        bit exp_rd;
        chk("busy", bus.busy, m_busy);
        chk("mem_wr", bus.mem_wr, m_wr);
        if (m_wr) begin
            chk("mem_addr", bus.mem_addr, m_addr);
            chk("mem_din", bus.mem_din, m_din);
        end
        reset           = rst_n;
        bus.start       = st;
        bus.base_addr   = b;
        bus.ofifo_valid = vld;
        bus.ofifo_out   = head;
`ifdef PSUM_WB_STALL_EN
        bus.mem_ready = mr;
        stall = m_wr & ~mr;
`else
        stall = 1'b0;
`endif
        #1;
        exp_rd = rst_n & m_busy & ~m_in_done & vld & ~stall;
        chk("ofifo_rd", bus.ofifo_rd, exp_rd);
        chk("done", bus.done, rst_n & m_in_done & ~stall);
        @(posedge clk);
        if (!rst_n) begin
            m_busy    = 1'b0;
            m_in_done = 1'b0;
            m_wr      = 1'b0;
            m_idx     = 0;
        end else begin
            if (exp_rd) begin
                m_wr   = 1'b1;
                m_addr = m_base + addr_t'(m_idx);
                m_din  = head;
                head   = rnd_vec();
            end else if (!stall) begin
                m_wr = 1'b0;
            end
            if (m_in_done && !stall) begin
                m_in_done = 1'b0;
                m_busy    = 1'b0;
            end else if (exp_rd) begin
                if (m_idx == TOTAL - 1) m_in_done = 1'b1;
                m_idx++;
            end else if (!m_busy && st) begin
                m_busy = 1'b1;
                m_idx  = 0;
                m_base = b;
            end
        end
        @(negedge clk);
    endtask

    // mode 0: continuous valid, 1: alternating, 2: random valid/ready, 3: 3-cycle stall on 2nd write
    task automatic run_pass(input addr_t b, input int mode);
        int k;
        bit vld;
        k = 0;
        do_cycle(1'b1, 1'b1, b, 1'b0);
        while (m_busy && k < 200) begin
            case (mode)
                0:       vld = 1'b1;
                1:       vld = (k % 2) == 0;
                2:       vld = $urandom_range(0, 2) != 0;
                default: vld = 1'b1;
            endcase
            if (mode == 3)      mr = !(k >= 2 && k <= 4);
            else if (mode == 2) mr = $urandom_range(0, 3) != 0;
            else                mr = 1'b1;
            do_cycle(1'b1, 1'($urandom_range(0, 1)), addr_t'($urandom), vld);
            k++;
        end
        mr = 1'b1;
        chk("pass_end_busy", bus.busy, 1'b0);
    endtask

    initial begin
        m_busy = 0; m_in_done = 0; m_wr = 0; m_idx = 0;
        m_base = '0; m_addr = '0; m_din = '0; mr = 1'b1;
        head            = rnd_vec();
        reset           = 1'b0;
        bus.start       = 1'b1;
        bus.base_addr   = '0;
        bus.ofifo_valid = 1'b1;
        bus.ofifo_out   = head;
`ifdef PSUM_WB_STALL_EN
        bus.mem_ready = 1'b1;
`endif
        @(posedge clk);
        @(negedge clk);

        do_cycle(1'b0, 1'b1, 11'd5, 1'b1);
        do_cycle(1'b0, 1'b1, 11'd5, 1'b1);
        chk("rst_mem_addr", bus.mem_addr, '0);
        chk("rst_mem_din", bus.mem_din, '0);
        do_cycle(1'b1, 1'b0, 11'd0, 1'b1);

        run_pass(11'd16, 0);
        run_pass(11'd100, 1);
        run_pass(11'd2046, 0);

        // Abort after three pops, then restart from a fresh base.
        do_cycle(1'b1, 1'b1, 11'd500, 1'b0);
        repeat (3) do_cycle(1'b1, 1'b0, 11'd0, 1'b1);
        do_cycle(1'b0, 1'b0, 11'd0, 1'b1);
        run_pass(11'd40, 2);

        run_pass(11'd300, 3);
        run_pass(11'd2040, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
